// File: rtl/subservient_status_gpio.sv
// subservient_status_gpio: Wishbone pass/fail GPIO reporter with watchdog; define STATUS_SIG_EN to add the SIG register
module subservient_status_gpio #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int WDT_W = 24,
  parameter logic [WDT_W-1:0] WDT_DEFAULT = 24'hFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [1:0]  io_out,
  output logic [1:0]  io_oeb,
  output logic        irq_o
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  state_t state, state_n;
  logic [WDT_W-1:0] wdt_load, count, count_n, load_n;
  logic timeout, timeout_n, hit, wr, wr_ctrl, wr_load, expire, done, unused_bits;
  logic [31:0] mask, wdat, rdata, sig_q;
  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign wr = hit & wbs_we_i & ~wbs_ack_o;
  assign wr_ctrl = wr & (wbs_adr_i[3:2] == 2'd0);
  assign wr_load = wr & (wbs_adr_i[3:2] == 2'd1);
  assign mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wdat = wbs_dat_i & mask;
  assign load_n = (wdt_load & ~mask[WDT_W-1:0]) | wdat[WDT_W-1:0];
  assign expire = (state == RUN) & (count[WDT_W-1:1] == '0);
  assign done = (state == PASS) | (state == FAIL);
  assign io_oeb = 2'b00;
  assign rdata = (wbs_adr_i[3:2] == 2'd0) ? {22'd0, state == RUN, state == RUN, 5'd0, timeout, state == FAIL, state == PASS} :
                 (wbs_adr_i[3:2] == 2'd1) ? 32'(wdt_load) :
                 (wbs_adr_i[3:2] == 2'd2) ? 32'(count) : sig_q;
`ifdef STATUS_SIG_EN
  logic [31:0] sig;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) sig <= '0;
    else if (wr && wbs_adr_i[3:2] == 2'd3 && !done) sig <= {sig[30:0], sig[31]} ^ wdat;
  assign sig_q = sig;
  assign unused_bits = ^wbs_adr_i[1:0];
`else
  assign sig_q = '0;
  assign unused_bits = ^{wbs_adr_i[1:0], wdat[31:WDT_W]};
`endif
  // a kick beats a same-cycle expiry; any other write loses to it
  always_comb begin
    state_n = state;
    count_n = count;
    timeout_n = timeout;
    case (state)
      IDLE: if (wr_ctrl) begin
        state_n = wdat[1] ? FAIL : wdat[0] ? PASS : wdat[8] ? RUN : IDLE;
        count_n = (state_n == RUN) ? wdt_load : count;
      end
      RUN: if (wr_load) count_n = load_n;
        else if (expire) begin
          state_n = FAIL;
          timeout_n = 1'b1;
          count_n = '0;
        end else begin
          count_n = count - 1'b1;
          if (wr_ctrl) state_n = wdat[1] ? FAIL : wdat[0] ? PASS : wdat[8] ? RUN : IDLE;
        end
      default: ;
    endcase
  end
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state <= IDLE;
      count <= '0;
      timeout <= 1'b0;
      wdt_load <= WDT_DEFAULT;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      io_out <= 2'b00;
      irq_o <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      timeout <= timeout_n;
      if (wr_load) wdt_load <= load_n;
      wbs_ack_o <= hit & ~wbs_ack_o;
      wbs_dat_o <= (hit & ~wbs_ack_o) ? rdata : '0;
      io_out <= {state_n == FAIL, state_n == PASS};
      irq_o <= (state_n == FAIL) | (state_n == PASS);
    end
endmodule
